input_sync_debounce: RTL and testbench
======================================

// Module: input_sync_debounce
// PURPOSE
//   Conditions raw asynchronous inputs (switches, buttons, off-chip strobes) before they reach the D flip-flop
//   stages as their d input. Per channel it provides:
//   - a multi-flop synchronizer;
//   - a consecutive-sample debounce filter;
//   - registered one-cycle rise/fall pulses.
//   Sits directly upstream of the storage flops; dout drives their d.
// PARAMETERS
//   WIDTH            1   number of independent input channels
//   SYNC_STAGES      2   synchronizer depth in flops; legal >= 2
//   DEBOUNCE_CYCLES  4   consecutive mismatching samples required to accept a new level; legal >= 1
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)   counter width; derived, not overridden
// PORTS
//   clk    input   1      rising-edge clock
//   rst    input   1      asynchronous, active-high reset
//   din    input   WIDTH  raw asynchronous inputs
//   dout   output  WIDTH  synchronized, debounced level (registered)
//   rise   output  WIDTH  one-cycle pulse when dout goes 0->1 (registered)
//   fall   output  WIDTH  one-cycle pulse when dout goes 1->0 (registered)
// BEHAVIOUR
//   Reset and clocking
//   - rst high clears all flops immediately, without waiting for a clock edge:
//     sync chain, counters, dout, rise and fall all go to 0.
//   - All state updates on the rising edge of clk only.
//   Synchronizer
//   - Per channel, s[0] <= din; s[k] <= s[k-1].
//   - s_last = s[SYNC_STAGES-1]; no logic between sync flops.
//   Debounce (per channel, evaluated at each edge)
//   - s_last == dout: cnt <= 0.
//   - s_last != dout, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - s_last != dout, cnt == DEBOUNCE_CYCLES-1: dout <= s_last; cnt <= 0.
//   Pulses
//   - rise <= (accepting a change) & s_last.
//   - fall <= (accepting a change) & ~s_last.
//   - Both go high on the same edge dout changes, for exactly one cycle; never both high together.
//   Latency
//   - A clean din step is reflected on dout after exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges,
//     counted from the first edge that samples the new value (defaults: 6).
//   Glitch rejection
//   - A mismatch at s_last lasting fewer than DEBOUNCE_CYCLES samples does not change dout, and clears cnt.
//   - Any reversal restarts the count from 0.
//   Boundary conditions
//   - DEBOUNCE_CYCLES=1: filter is transparent; latency is SYNC_STAGES+1 edges.
//   - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
//   - din high at reset release: dout starts 0, then rises after the full latency, with one rise pulse.
//   - rst asserted mid-count or mid-pulse: the count is aborted, dout/rise/fall drop at once,
//     and nothing is retained after release.
//   - Channels are fully independent; simultaneous events on different channels do not interact.
// TESTING
//   1. rst=1 for 3 cycles, din random
//      -> dout/rise/fall all 0 during reset, including between clock edges.
//   2. Defaults, din 0->1 held
//      -> dout=1 on the 6th edge after sampling; rise high for exactly that one cycle; fall stays 0.
//   3. din 1-cycle and 3-cycle high glitches on a 0 baseline -> dout stays 0; no rise pulse.
//   4. Bounce din 1,0,1,1,0,1,1,1,1 at one sample per cycle
//      -> dout goes 1 only after 4 consecutive 1s reach s_last; exactly one rise pulse.
//   5. rst pulsed while cnt=2, with dout=1 and din=0
//      -> dout stays 0 after release; no fall pulse ever seen.
//   6. WIDTH=2, ch0 0->1 and ch1 1->0 on the same edge
//      -> rise[0] and fall[1] pulse on the same cycle; each channel sees only its own pulse.

Source files
------------

// File: rtl/input_sync_debounce.sv
// input_sync_debounce
// Conditions raw asynchronous inputs before they feed downstream storage
// flops. Each channel runs an independent multi-flop synchronizer, a
// consecutive-sample debounce filter and registered rise/fall pulse outputs.
// dout is a clean, registered level that is safe to use as a flop d input.

module input_sync_debounce #(
    parameter int WIDTH           = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so this width never wraps.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s_last;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_next;
        logic                   accept;
        logic                   dout_q;
        logic                   rise_q;
        logic                   fall_q;

        // Plain shift chain for metastability settling; nothing sits between the flops.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], din[ch]};
            end
        end

        assign s_last = sync_q[SYNC_STAGES-1];

        // Count consecutive samples that disagree with dout; any agreeing sample restarts the count.
        always_comb begin
            cnt_next = '0;
            accept   = 1'b0;
            if (s_last != dout_q) begin
                if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_next = cnt_q + CNT_W'(1);
                end
            end
        end

        // Register the filtered level and the one-cycle edge pulses on the same edge it changes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                dout_q <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_next;
                rise_q <= accept & s_last;
                fall_q <= accept & ~s_last;
                if (accept) begin
                    dout_q <= s_last;
                end
            end
        end

        assign dout[ch] = dout_q;
        assign rise[ch] = rise_q;
        assign fall[ch] = fall_q;
    end

endmodule

// File: tb/tb_input_sync_debounce.sv
// tb_input_sync_debounce
// Directed bench for input_sync_debounce: a two-channel instance with default
// filtering and a single-channel instance with a one-sample (transparent) filter.

module tb_input_sync_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] din;
    logic [1:0] dout;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [0:0] dout1;
    logic [0:0] rise1;
    logic [0:0] fall1;

    int checkCount;
    int errorCount;

    input_sync_debounce #(
        .WIDTH           (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall)
    );

    input_sync_debounce #(
        .WIDTH           (1),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1)
    ) dut1 (
        .clk  (clk),
        .rst  (rst),
        .din  (din[0:0]),
        .dout (dout1),
        .rise (rise1),
        .fall (fall1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive din, then let the given number of rising edges pass and settle 1 time unit past the last one.
    task automatic applyStimulus(input logic [1:0] value, input int cycles);
        din = value;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        logic [14:0] glitchPat;
        logic [8:0]  bouncePat;

        checkCount = 0;
        errorCount = 0;
        din = 2'b00;
        rst = 1'b0;

        // Reset: outputs clear immediately and stay clear while rst is held.
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_async_dout", dout, 2'b00);
        checkOutput("reset_async_rise", rise, 2'b00);
        checkOutput("reset_async_fall", fall, 2'b00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1);
            checkOutput("reset_edge_dout", dout, 2'b00);
            checkOutput("reset_edge_pulses", rise | fall, 2'b00);
            #4;
            checkOutput("reset_mid_dout", dout, 2'b00);
            checkOutput("reset_mid_dut1", {1'b0, dout1}, 2'b00);
        end
        rst = 1'b0;
        applyStimulus(2'b00, 8);
        checkOutput("idle_dout", dout, 2'b00);

        // Clean step 0->1: transparent filter at edge 3, default filter at edge 6.
        $display("[TB] clean step");
        applyStimulus(2'b01, 2);
        checkOutput("dut1_e2_dout", {1'b0, dout1}, 2'b00);
        applyStimulus(2'b01, 1);
        checkOutput("dut1_e3_dout", {1'b0, dout1}, 2'b01);
        checkOutput("dut1_e3_rise", {1'b0, rise1}, 2'b01);
        checkOutput("step_e3_dout", dout, 2'b00);
        applyStimulus(2'b01, 2);
        checkOutput("step_e5_dout", dout, 2'b00);
        checkOutput("step_e5_rise", rise, 2'b00);
        checkOutput("dut1_e5_rise", {1'b0, rise1}, 2'b00);
        applyStimulus(2'b01, 1);
        checkOutput("step_e6_dout", dout, 2'b01);
        checkOutput("step_e6_rise", rise, 2'b01);
        checkOutput("step_e6_fall", fall, 2'b00);
        applyStimulus(2'b01, 1);
        checkOutput("step_e7_rise", rise, 2'b00);
        checkOutput("step_e7_dout", dout, 2'b01);

        // Clean step 1->0 back to baseline, with a single fall pulse.
        applyStimulus(2'b00, 5);
        checkOutput("fallstep_e5_dout", dout, 2'b01);
        checkOutput("fallstep_e5_fall", fall, 2'b00);
        applyStimulus(2'b00, 1);
        checkOutput("fallstep_e6_dout", dout, 2'b00);
        checkOutput("fallstep_e6_fall", fall, 2'b01);
        checkOutput("fallstep_e6_rise", rise, 2'b00);
        applyStimulus(2'b00, 1);
        checkOutput("fallstep_e7_fall", fall, 2'b00);

        // Glitches of 1 and 3 samples, then a 1-sample glitch right after the 3-sample one.
        $display("[TB] glitch rejection");
        glitchPat = 15'b000000101110001;
        for (int i = 0; i < 15; i++) begin
            applyStimulus({1'b0, glitchPat[i]}, 1);
            checkOutput("glitch_dout", dout, 2'b00);
            checkOutput("glitch_rise", rise, 2'b00);
        end

        // Bounce 1,0,1,1,0,1,1,1,1: accepted at the edge seeing the fourth consecutive 1.
        $display("[TB] bounce");
        bouncePat = 9'b111101101;
        for (int i = 0; i < 9; i++) begin
            applyStimulus({1'b0, bouncePat[i]}, 1);
            checkOutput("bounce_dout", dout, 2'b00);
            checkOutput("bounce_rise", rise, 2'b00);
        end
        applyStimulus(2'b01, 1);
        checkOutput("bounce_e10_dout", dout, 2'b00);
        applyStimulus(2'b01, 1);
        checkOutput("bounce_e11_dout", dout, 2'b01);
        checkOutput("bounce_e11_rise", rise, 2'b01);
        applyStimulus(2'b01, 1);
        checkOutput("bounce_e12_rise", rise, 2'b00);

        // Reset mid-count: dout=1, din=0, count at 2 when rst pulses.
        $display("[TB] reset mid-count");
        applyStimulus(2'b00, 4);
        checkOutput("midcnt_pre_dout", dout, 2'b01);
        #2 rst = 1'b1;
        #1;
        checkOutput("midcnt_async_dout", dout, 2'b00);
        applyStimulus(2'b00, 1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b00, 1);
            checkOutput("midcnt_after_dout", dout, 2'b00);
            checkOutput("midcnt_after_fall", fall, 2'b00);
        end

        // din already high when reset releases: dout starts 0, rises after the full latency.
        $display("[TB] high at release");
        rst = 1'b1;
        applyStimulus(2'b01, 2);
        rst = 1'b0;
        applyStimulus(2'b01, 5);
        checkOutput("relhigh_e5_dout", dout, 2'b00);
        applyStimulus(2'b01, 1);
        checkOutput("relhigh_e6_dout", dout, 2'b01);
        checkOutput("relhigh_e6_rise", rise, 2'b01);
        applyStimulus(2'b01, 1);
        checkOutput("relhigh_e7_rise", rise, 2'b00);

        // Two channels moving in opposite directions on the same edge.
        $display("[TB] channel independence");
        applyStimulus(2'b10, 5);
        checkOutput("chan_a_e5_dout", dout, 2'b01);
        applyStimulus(2'b10, 1);
        checkOutput("chan_a_e6_dout", dout, 2'b10);
        checkOutput("chan_a_e6_rise", rise, 2'b10);
        checkOutput("chan_a_e6_fall", fall, 2'b01);
        applyStimulus(2'b01, 5);
        checkOutput("chan_b_e5_dout", dout, 2'b10);
        checkOutput("chan_b_e5_pulses", rise | fall, 2'b00);
        applyStimulus(2'b01, 1);
        checkOutput("chan_b_e6_dout", dout, 2'b01);
        checkOutput("chan_b_e6_rise", rise, 2'b01);
        checkOutput("chan_b_e6_fall", fall, 2'b10);
        applyStimulus(2'b01, 1);
        checkOutput("chan_b_e7_pulses", rise | fall, 2'b00);

        // Reset while a rise pulse is high: pulse and level drop at once, nothing retained.
        $display("[TB] reset mid-pulse");
        applyStimulus(2'b11, 6);
        checkOutput("midpulse_pre_dout", dout, 2'b11);
        checkOutput("midpulse_pre_rise", rise, 2'b10);
        #2 rst = 1'b1;
        #1;
        checkOutput("midpulse_async_dout", dout, 2'b00);
        checkOutput("midpulse_async_rise", rise, 2'b00);
        checkOutput("midpulse_async_fall", fall, 2'b00);
        #2 rst = 1'b0;
        applyStimulus(2'b11, 3);
        checkOutput("midpulse_after_dout", dout, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
